// File: rtl/triangle_feeder.sv
// triangle_feeder
//   Assembles a serial stream of 32-bit words into 15-word triangle records
//   (x1 y1 z1 rgb1 x2 y2 z2 rgb2 x3 y3 z3 rgb3 nx ny nz) and presents each
//   record on a parallel valid/stall interface. An assembly buffer and an
//   output register let the next triangle fill while the current one is
//   held by a stalled downstream stage.
//
// Ports
//   clock           single clock, all state on posedge
//   reset           asynchronous, active-low
//   word_in         stream word
//   word_valid      word_in is valid
//   word_last       word_in is the final word of the final triangle
//   word_ready      feeder accepts word_in this cycle
//   flush           discard partial assembly, clear done/err/count
//   v_out           triangle record, index = word order
//   color_out1..3   bits [23:0] of words 3 / 7 / 11
//   out_data_valid  v_out / color_out hold a valid record
//   stall_in        downstream busy, record not taken this cycle
//   done_out        last-tagged triangle has been transferred (sticky)
//   err_out         word_last seen on a word other than the final one (sticky)
//   tri_count       triangles transferred since reset/flush
module triangle_feeder #(
    parameter int CNT_W     = 16,
    parameter int NUM_WORDS = 15
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [31:0]                 word_in,
    input  logic                        word_valid,
    input  logic                        word_last,
    output logic                        word_ready,
    input  logic                        flush,
    output logic [NUM_WORDS-1:0][31:0]  v_out,
    output logic [23:0]                 color_out1,
    output logic [23:0]                 color_out2,
    output logic [23:0]                 color_out3,
    output logic                        out_data_valid,
    input  logic                        stall_in,
    output logic                        done_out,
    output logic                        err_out,
    output logic [CNT_W-1:0]            tri_count
);

    localparam int                IDX_W    = $clog2(NUM_WORDS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);

    // IDLE exists only so word_ready stays low for the first clock after reset
    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_FULL
    } state_t;

    state_t                       state;
    state_t                       state_next;
    logic [IDX_W-1:0]             idx;
    logic [NUM_WORDS-1:0][31:0]   asm_buf;
    logic                         asm_last;
    logic                         out_last;
    logic [NUM_WORDS-1:0][31:0]   direct_rec;

    logic accept;
    logic at_last;
    logic transfer;
    logic out_free;
    logic direct_move;
    logic full_move;

    // flush drops any word offered in the same cycle
    assign accept      = word_valid && (state == S_FILL) && !flush;
    assign at_last     = (idx == LAST_IDX);
    assign transfer    = out_data_valid && !stall_in;
    assign out_free    = !out_data_valid || transfer;
    // final word goes straight to the output register when it is free,
    // otherwise the record parks in the assembly buffer (FULL)
    assign direct_move = accept && at_last && out_free;
    assign full_move   = (state == S_FULL) && out_free && !flush;

    assign color_out1 = v_out[3][23:0];
    assign color_out2 = v_out[7][23:0];
    assign color_out3 = v_out[11][23:0];

    // Record seen by a direct move: buffered words plus the word on the bus
    always_comb begin
        direct_rec                = asm_buf;
        direct_rec[NUM_WORDS-1]   = word_in;
    end

    // Assembly FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Assembly FSM next state and ready
    always_comb begin
        state_next = state;
        word_ready = 1'b0;
        case (state)
            S_IDLE: begin
                state_next = S_FILL;
            end
            S_FILL: begin
                word_ready = 1'b1;
                if (accept && at_last && !word_last && !out_free) begin
                    state_next = S_FULL;
                end else if (accept && at_last && word_last && !out_free) begin
                    state_next = S_FULL;
                end
            end
            S_FULL: begin
                if (flush || out_free) begin
                    state_next = S_FILL;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Word index and assembly buffer
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx      <= '0;
            asm_buf  <= '0;
            asm_last <= 1'b0;
        end else begin
            if (flush) begin
                idx <= '0;
            end else if (accept) begin
                // a misplaced word_last discards the partial record
                if (at_last || word_last) begin
                    idx <= '0;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
            if (accept) begin
                asm_buf[idx] <= word_in;
            end
            if (accept && at_last) begin
                asm_last <= word_last;
            end
        end
    end

    // Output register; a move in the same cycle as a transfer keeps valid high
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            v_out          <= '0;
            out_last       <= 1'b0;
            out_data_valid <= 1'b0;
        end else begin
            if (direct_move) begin
                v_out          <= direct_rec;
                out_last       <= word_last;
                out_data_valid <= 1'b1;
            end else if (full_move) begin
                v_out          <= asm_buf;
                out_last       <= asm_last;
                out_data_valid <= 1'b1;
            end else if (transfer) begin
                out_data_valid <= 1'b0;
            end
        end
    end

    // Status flags and transfer counter; flush takes priority
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tri_count <= '0;
            done_out  <= 1'b0;
            err_out   <= 1'b0;
        end else if (flush) begin
            tri_count <= '0;
            done_out  <= 1'b0;
            err_out   <= 1'b0;
        end else begin
            if (transfer) begin
                tri_count <= tri_count + CNT_W'(1);
            end
            if (transfer && out_last) begin
                done_out <= 1'b1;
            end
            if (accept && word_last && !at_last) begin
                err_out <= 1'b1;
            end
        end
    end

endmodule
